// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine credit/game controller.
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    STOPPED1,
    STOPPED2,
    JUDGE,
    PAYOUT
  } state_e;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PAIR   = 2'd2;
  localparam logic [1:0] WIN_TRIPLE = 2'd3;

  localparam int CREDIT_MAX = 99;

  function automatic logic [1:0] judge_reels(input logic [3:0] r1,
                                             input logic [3:0] r2,
                                             input logic [3:0] r3);
    if (r1 == r2 && r2 == r3) return WIN_TRIPLE;
    if (r1 == r2 || r2 == r3 || r1 == r3) return WIN_PAIR;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/btn_event.sv
// Button conditioning: 2-flop synchroniser, optional debouncer, one-cycle rising-edge pulse.
// Debouncer present only when SLOT_DEBOUNCE_EN is defined.
module btn_event
`ifdef SLOT_DEBOUNCE_EN
#(
  parameter int DB_CYCLES = 16
)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync0_q, sync1_q;
  logic level_w;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= btn_i;
      sync1_q <= sync0_q;
    end
  end

`ifdef SLOT_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LOAD = CW'(DB_CYCLES - 1);

  logic          db_q;
  logic [CW-1:0] db_cnt_q;

  // Down-counter reloads whenever the input agrees with the debounced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q     <= 1'b0;
      db_cnt_q <= DB_LOAD;
    end else if (sync1_q == db_q) begin
      db_cnt_q <= DB_LOAD;
    end else if (db_cnt_q == '0) begin
      db_q     <= sync1_q;
      db_cnt_q <= DB_LOAD;
    end else begin
      db_cnt_q <= db_cnt_q - 1'b1;
    end
  end

  assign level_w = db_q;
`else
  assign level_w = sync1_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level_w;
  end

  assign pulse_o = level_w & ~prev_q;

endmodule

// File: rtl/slot_credit_ctrl.sv
// Slot-machine game/credit controller: coin/start/stop handling, reel STOP sequencing, judging, payout.
// Optional SLOT_DEBOUNCE_EN adds a debouncer in each button path.
//
// state    | meaning
// IDLE     | waiting for a paid start; reels frozen
// SPIN     | all reels running
// STOPPED1 | reel 1 frozen
// STOPPED2 | reels 1-2 frozen
// JUDGE    | all frozen; compare reel digits
// PAYOUT   | add prize, return to IDLE
module slot_credit_ctrl #(
  parameter int COST       = 1,
  parameter int COIN_VALUE = 1,
  parameter int PRIZE_2    = 3,
  parameter int PRIZE_3    = 10,
  parameter int CREDIT_MAX = slot_pkg::CREDIT_MAX
`ifdef SLOT_DEBOUNCE_EN
  , parameter int DB_CYCLES = 16
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       C_IN,
  input  logic       GAME_START,
  input  logic       STOP_BTN,
  input  logic [3:0] REEL1,
  input  logic [3:0] REEL2,
  input  logic [3:0] REEL3,
  output logic [6:0] CREDIT,
  output logic       STOP1,
  output logic       STOP2,
  output logic       STOP3,
  output logic [1:0] WIN,
  output logic       BUSY
);

  import slot_pkg::*;

  logic coin_ev, start_ev, stop_ev;

`ifdef SLOT_DEBOUNCE_EN
  btn_event #(.DB_CYCLES(DB_CYCLES)) u_coin  (.clk_i(CLK), .rst_ni(RST), .btn_i(C_IN),       .pulse_o(coin_ev));
  btn_event #(.DB_CYCLES(DB_CYCLES)) u_start (.clk_i(CLK), .rst_ni(RST), .btn_i(GAME_START), .pulse_o(start_ev));
  btn_event #(.DB_CYCLES(DB_CYCLES)) u_stop  (.clk_i(CLK), .rst_ni(RST), .btn_i(STOP_BTN),   .pulse_o(stop_ev));
`else
  btn_event u_coin  (.clk_i(CLK), .rst_ni(RST), .btn_i(C_IN),       .pulse_o(coin_ev));
  btn_event u_start (.clk_i(CLK), .rst_ni(RST), .btn_i(GAME_START), .pulse_o(start_ev));
  btn_event u_stop  (.clk_i(CLK), .rst_ni(RST), .btn_i(STOP_BTN),   .pulse_o(stop_ev));
`endif

  state_e     state_q;
  logic [7:0] credit_q, credit_d;
  logic [2:0] stop_q;
  logic [1:0] win_q;
  logic       busy_q;
  logic       start_ok;

  assign start_ok = (state_q == IDLE) && start_ev && (int'(credit_q) >= COST);

  // Coin, prize and deduct all combine in one sum that is saturated once.
  always_comb begin
    int sum;
    sum = int'(credit_q);
    if (coin_ev)  sum = sum + COIN_VALUE;
    if (start_ok) sum = sum - COST;
    if (state_q == PAYOUT) begin
      if (win_q == WIN_TRIPLE)    sum = sum + PRIZE_3;
      else if (win_q == WIN_PAIR) sum = sum + PRIZE_2;
    end
    credit_d = (sum > CREDIT_MAX) ? 8'(CREDIT_MAX) : 8'(sum);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      credit_q <= 8'd0;
      stop_q   <= 3'b111;
      win_q    <= WIN_NONE;
      busy_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= SPIN;
            stop_q  <= 3'b000;
            win_q   <= WIN_NONE;
            busy_q  <= 1'b1;
          end
        end
        SPIN: begin
          if (stop_ev) begin
            state_q   <= STOPPED1;
            stop_q[0] <= 1'b1;
          end
        end
        STOPPED1: begin
          if (stop_ev) begin
            state_q   <= STOPPED2;
            stop_q[1] <= 1'b1;
          end
        end
        STOPPED2: begin
          if (stop_ev) begin
            state_q   <= JUDGE;
            stop_q[2] <= 1'b1;
          end
        end
        // Reels have been frozen for a full cycle by the time JUDGE samples them.
        JUDGE: begin
          win_q   <= judge_reels(REEL1, REEL2, REEL3);
          state_q <= PAYOUT;
        end
        PAYOUT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CREDIT = credit_q[6:0];
  assign STOP1  = stop_q[0];
  assign STOP2  = stop_q[1];
  assign STOP3  = stop_q[2];
  assign WIN    = win_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Directed self-checking bench for slot_credit_ctrl (default and SLOT_DEBOUNCE_EN builds).
module tb_slot_credit_ctrl;

`ifdef SLOT_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 4;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       C_IN, GAME_START, STOP_BTN;
  logic [3:0] REEL1, REEL2, REEL3;
  logic [6:0] CREDIT;
  logic       STOP1, STOP2, STOP3;
  logic [1:0] WIN;
  logic       BUSY;

  int n_checks = 0;
  int n_errors = 0;

  slot_credit_ctrl dut (
    .CLK(CLK), .RST(RST), .C_IN(C_IN), .GAME_START(GAME_START), .STOP_BTN(STOP_BTN),
    .REEL1(REEL1), .REEL2(REEL2), .REEL3(REEL3),
    .CREDIT(CREDIT), .STOP1(STOP1), .STOP2(STOP2), .STOP3(STOP3), .WIN(WIN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int stops();
    return int'({STOP3, STOP2, STOP1});
  endfunction

  // which: 0 coin, 1 start, 2 stop
  task automatic press(input int which);
    @(negedge CLK);
    case (which)
      0: C_IN = 1'b1;
      1: GAME_START = 1'b1;
      default: STOP_BTN = 1'b1;
    endcase
    repeat (HOLD) @(negedge CLK);
    C_IN = 1'b0; GAME_START = 1'b0; STOP_BTN = 1'b0;
    repeat (HOLD + 2) @(negedge CLK);
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) press(0);
  endtask

  task automatic play(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3);
    REEL1 = r1; REEL2 = r2; REEL3 = r3;
    press(1);
    chk("game_win_cleared", int'(WIN), 0);
    chk("game_busy", int'(BUSY), 1);
    repeat (3) press(2);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0; C_IN = 1'b0; GAME_START = 1'b0; STOP_BTN = 1'b0;
    REEL1 = 4'd0; REEL2 = 4'd0; REEL3 = 4'd0;
    repeat (3) @(negedge CLK);
    chk("rst_credit", int'(CREDIT), 0);
    chk("rst_stops", stops(), 7);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_win", int'(WIN), 0);
    RST = 1'b1;

    press(1);
    chk("start_nocredit_busy", int'(BUSY), 0);
    chk("start_nocredit_credit", int'(CREDIT), 0);

    coins(3);
    chk("coin3_credit", int'(CREDIT), 3);
    chk("coin3_stops", stops(), 7);
    chk("coin3_busy", int'(BUSY), 0);

    coins(2);
    REEL1 = 4'd7; REEL2 = 4'd7; REEL3 = 4'd7;
    press(1);
    chk("g1_start_busy", int'(BUSY), 1);
    chk("g1_start_credit", int'(CREDIT), 4);
    chk("g1_start_stops", stops(), 0);
    press(2);
    chk("g1_stop1", stops(), 1);
    press(1);
    chk("g1_start_ignored_credit", int'(CREDIT), 4);
    chk("g1_start_ignored_stops", stops(), 1);
    press(2);
    chk("g1_stop2", stops(), 3);
    press(2);
    chk("g1_stop3", stops(), 7);
    chk("g1_win", int'(WIN), 3);
    chk("g1_credit", int'(CREDIT), 14);
    chk("g1_idle", int'(BUSY), 0);
    press(2);
    chk("stop_in_idle_stops", stops(), 7);

    do_reset();
    chk("rst2_credit", int'(CREDIT), 0);
    coins(2);
    play(4'd4, 4'd9, 4'd4);
    chk("pair_win", int'(WIN), 2);
    chk("pair_credit", int'(CREDIT), 4);
    play(4'd1, 4'd2, 4'd3);
    chk("none_win", int'(WIN), 0);
    chk("none_credit", int'(CREDIT), 3);

    coins(92);
    chk("credit_95", int'(CREDIT), 95);
    play(4'd5, 4'd5, 4'd5);
    chk("sat_win", int'(WIN), 3);
    chk("sat_credit", int'(CREDIT), 99);
    press(0);
    chk("coin_at_max", int'(CREDIT), 99);

    // Coin pin leads into the PAYOUT cycle: both paths share the same latency.
    do_reset();
    coins(51);
    chk("credit_51", int'(CREDIT), 51);
    REEL1 = 4'd2; REEL2 = 4'd2; REEL3 = 4'd8;
    press(1);
    chk("sim_after_deduct", int'(CREDIT), 50);
    press(2);
    press(2);
    @(negedge CLK); STOP_BTN = 1'b1;
    repeat (2) @(negedge CLK);
    C_IN = 1'b1;
    repeat (HOLD) @(negedge CLK);
    STOP_BTN = 1'b0; C_IN = 1'b0;
    repeat (HOLD + 4) @(negedge CLK);
    chk("sim_win", int'(WIN), 2);
    chk("sim_credit", int'(CREDIT), 54);

    press(1);
    chk("mid_spin_busy", int'(BUSY), 1);
    @(negedge CLK); RST = 1'b0;
    #1;
    chk("midrst_credit", int'(CREDIT), 0);
    chk("midrst_stops", stops(), 7);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_win", int'(WIN), 0);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slot_credit_ctrl.md
Name: slot_credit_ctrl

Overview:
- Game/credit controller directly upstream of the slot-machine display top.
- Accepts coin-insert, start and stop buttons; keeps the 0..99 credit balance; sequences the three reel STOP signals.
- Judges the stopped reel digits and pays out.
- Outputs CREDIT (to the binary-to-BCD/7-seg path) and STOP1..STOP3 (to the reel counters).

Parameters:
- COST, 1, credits deducted per game.
- COIN_VALUE, 1, credits added per coin pulse.
- PRIZE_2, 3, credits paid when exactly two reels match.
- PRIZE_3, 10, credits paid when all three reels match.
- CREDIT_MAX, 99, saturation ceiling for the balance.
- DB_CYCLES, 16, stable cycles required by the debouncer (used only with the optional feature).

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-low reset
- C_IN  input  1  coin-insert button, asynchronous, active-high
- GAME_START  input  1  start button, asynchronous, active-high
- STOP_BTN  input  1  reel-stop button, asynchronous, active-high
- REEL1  input  4  current BCD digit of reel 1
- REEL2  input  4  current BCD digit of reel 2
- REEL3  input  4  current BCD digit of reel 3
- CREDIT  output  7  credit balance, binary 0..99
- STOP1  output  1  freeze reel 1 (level)
- STOP2  output  1  freeze reel 2 (level)
- STOP3  output  1  freeze reel 3 (level)
- WIN  output  2  last result: 0 none, 2 pair, 3 triple
- BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Reset (RST=0, async): state IDLE, CREDIT=0, STOP1..3=1 (reels frozen), WIN=0, BUSY=0, all synchroniser/edge flops cleared.
- Input conditioning:
  - Every button passes a 2-flop synchroniser, then a rising-edge detector.
  - An event is one CLK-cycle pulse, and only one per press.
  - Event latency is 3 cycles from the pin.
- Coin event:
  - In any state: CREDIT = min(CREDIT+COIN_VALUE, CREDIT_MAX).
  - At 99 the event is dropped and CREDIT holds.
- FSM states: IDLE, SPIN, STOPPED1, STOPPED2, JUDGE, PAYOUT.
- IDLE:
  - Start event with CREDIT>=COST: CREDIT -= COST, STOP1..3=0, WIN=0, go to SPIN.
  - Start event with CREDIT<COST: ignored, stay in IDLE.
- SPIN: stop event sets STOP1=1, go to STOPPED1.
- STOPPED1: stop event sets STOP2=1, go to STOPPED2.
- STOPPED2: stop event sets STOP3=1, go to JUDGE.
- JUDGE:
  - One cycle long. It samples REEL1..3 one cycle after STOP3 rose, so the reel counters have frozen.
  - REEL1==REEL2==REEL3 gives WIN=3.
  - Any single equal pair gives WIN=2.
  - Otherwise WIN=0.
  - Go to PAYOUT.
- PAYOUT:
  - CREDIT = min(CREDIT + prize, CREDIT_MAX), where prize follows WIN (0 for WIN=0).
  - Go to IDLE next cycle. WIN holds until the next game starts.
- Start events outside IDLE are ignored. Stop events in IDLE, JUDGE and PAYOUT are ignored.
- Coin and payout in the same cycle: both adds apply in that cycle, and the sum is saturated once at CREDIT_MAX.
- Coin and start (deduct) in the same cycle: CREDIT_next = CREDIT + COIN_VALUE - COST, saturated. The affordability check uses the pre-update CREDIT.
- Arithmetic: CREDIT is internally 8 bits wide to avoid overflow before saturation and is truncated to 7 bits at the output. It never goes negative.
- Reset mid-game: async return to the reset state. The consumed credit is not refunded.

Optional Feature:
- Macro: SLOT_DEBOUNCE_EN.
- Defined: each synchronised button must be stable for DB_CYCLES consecutive cycles before its debounced level changes. The edge detector operates on the debounced level, so event latency is 3+DB_CYCLES cycles. Glitches shorter than DB_CYCLES produce no event.
- Undefined: no debouncer; edge detection acts directly on the synchroniser output.

Decomposition:
- Shared package slot_pkg holds:
  - The state enum (IDLE, SPIN, STOPPED1, STOPPED2, JUDGE, PAYOUT).
  - WIN codes: WIN_NONE=0, WIN_PAIR=2, WIN_TRIPLE=3.
  - The CREDIT_MAX constant.
- One sub-module, btn_event:
  - Contains synchroniser, optional debouncer, and rising-edge pulse.
  - Instantiated three times: C_IN, GAME_START, STOP_BTN.

Test Plan:
- Reset then 3 coin presses -> CREDIT=3; STOP1..3=1; BUSY=0.
- CREDIT=0, press start -> no transition; BUSY stays 0; CREDIT=0.
- CREDIT=5, start, force REEL1..3=7,7,7, three stop presses -> STOP1, STOP2, STOP3 rise in order, one per press. In JUDGE, WIN=3. After PAYOUT, CREDIT=5-1+10=14, then IDLE.
- CREDIT=2, game with reels 4,9,4 -> WIN=2, CREDIT=4. Repeat with reels 1,2,3 -> WIN=0, CREDIT=3.
- CREDIT=95, triple win -> CREDIT saturates at 99. Further coin press -> CREDIT stays 99.
- Coin event and PAYOUT in the same cycle with CREDIT=50 after deduct, pair win -> CREDIT=54. Assert RST mid-SPIN -> immediate reset values, CREDIT=0.
